// File: rtl/deser_load_ctrl.sv
// deser_load_ctrl: framed serial-to-parallel loader with optional even parity and a one-cycle load strobe
module deser_load_ctrl #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1,
  parameter bit PARITY_EN = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             load,
  output logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             error
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, LOAD} state_t;
  state_t           state, nxt;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sr, sr_n, data_n, shifted;
  logic             err_n, xfer;
  assign in_ready = (state == SHIFT) || (state == PARITY);
  assign busy     = in_ready;
  assign load     = state == LOAD;
  assign xfer     = in_valid & in_ready;
  assign shifted  = MSB_FIRST ? {sr[WIDTH-2:0], in_bit} : {in_bit, sr[WIDTH-1:1]};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
      data  <= '0;
      error <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= cnt_n;
      sr    <= sr_n;
      data  <= data_n;
      error <= err_n;
    end
  // start wins in every state: it opens a fresh frame and drops any bit transferred alongside it
  always_comb begin
    nxt    = state;
    cnt_n  = cnt;
    sr_n   = sr;
    data_n = data;
    err_n  = error;
    if (start) begin
      nxt   = SHIFT;
      cnt_n = '0;
      sr_n  = '0;
      err_n = 1'b0;
    end else begin
      case (state)
        SHIFT: if (xfer) begin
          sr_n  = shifted;
          cnt_n = cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            nxt    = PARITY_EN ? PARITY : LOAD;
            data_n = PARITY_EN ? data : shifted;
          end
        end
        PARITY: if (xfer) begin
          nxt    = (^{sr, in_bit}) ? IDLE : LOAD;
          data_n = (^{sr, in_bit}) ? data : sr;
          err_n  = ^{sr, in_bit};
        end
        LOAD:    nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_deser_load_ctrl.sv
// tb_deser_load_ctrl: directed checks of three configurations (MSB-first, LSB-first, parity) on a shared stimulus bus
module tb_deser_load_ctrl;
  logic       clk = 1'b0, reset = 1'b0, start = 1'b0, in_valid = 1'b0, in_bit = 1'b0;
  logic [2:0] rdy, ld, bsy, er;
  logic [7:0] dat [3];
  int         n_vec = 0, n_bad = 0, loads_a = 0, mark;
  always #5 clk = ~clk;
  deser_load_ctrl #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(0)) u_a (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(rdy[0]), .load(ld[0]), .data(dat[0]), .busy(bsy[0]), .error(er[0]));
  deser_load_ctrl #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(0)) u_b (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(rdy[1]), .load(ld[1]), .data(dat[1]), .busy(bsy[1]), .error(er[1]));
  deser_load_ctrl #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(1)) u_c (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(rdy[2]), .load(ld[2]), .data(dat[2]), .busy(bsy[2]), .error(er[2]));
  always @(posedge clk) if (ld[0]) loads_a <= loads_a + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic send_bit(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic send_msb(input logic [7:0] w, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) send_bit(w[i]);
  endtask
  initial begin
    #1;
    chk("rst_ready", rdy[0], 0);
    chk("rst_busy", bsy[0], 0);
    chk("rst_load", ld[0], 0);
    chk("rst_data", dat[0], 0);
    chk("rst_error", er[0], 0);
    #20 reset = 1'b1;
    tick();
    go();
    chk("a_busy_start", bsy[0], 1);
    chk("a_ready_start", rdy[0], 1);
    send_msb(8'hA5, 7);
    chk("a_no_load_7", ld[0], 0);
    send_bit(1'b1);
    chk("a_load", ld[0], 1);
    chk("a_data", dat[0], 8'hA5);
    chk("a_busy_load", bsy[0], 0);
    chk("a_ready_load", rdy[0], 0);
    tick();
    chk("a_load_once", ld[0], 0);
    chk("a_data_hold", dat[0], 8'hA5);
    go();
    for (int i = 0; i < 4; i++) send_bit(i[0] == 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b_gap_busy", bsy[1], 1);
    end
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("b_no_load_7", ld[1], 0);
    send_bit(1'b1);
    chk("b_load", ld[1], 1);
    chk("b_data", dat[1], 8'hA5);
    tick();
    go();
    send_msb(8'hA5, 8);
    chk("c_busy_parity", bsy[2], 1);
    chk("c_no_load_data", ld[2], 0);
    send_bit(1'b0);
    chk("c_load", ld[2], 1);
    chk("c_data", dat[2], 8'hA5);
    chk("c_error_ok", er[2], 0);
    tick();
    go();
    send_msb(8'h3C, 8);
    send_bit(1'b1);
    chk("c_bad_no_load", ld[2], 0);
    chk("c_bad_error", er[2], 1);
    chk("c_bad_data", dat[2], 8'hA5);
    chk("c_bad_busy", bsy[2], 0);
    tick();
    chk("c_error_sticky", er[2], 1);
    go();
    chk("c_error_clear", er[2], 0);
    mark = loads_a;
    go();
    send_msb(8'hFF, 5);
    tick();
    chk("r_no_load_5", ld[0], 0);
    go();
    chk("r_busy", bsy[0], 1);
    send_msb(8'hFF, 8);
    chk("r_load", ld[0], 1);
    chk("r_data", dat[0], 8'hFF);
    tick();
    chk("r_load_count", loads_a - mark, 1);
    go();
    send_msb(8'h5A, 4);
    #2 reset = 1'b0;
    #1;
    chk("x_ready", rdy[0], 0);
    chk("x_busy", bsy[0], 0);
    chk("x_load", ld[0], 0);
    chk("x_data", dat[0], 0);
    chk("x_error", er[0], 0);
    #2 reset = 1'b1;
    tick();
    go();
    send_msb(8'h5A, 8);
    chk("x_reload", ld[0], 1);
    chk("x_redata", dat[0], 8'h5A);
    tick();
    mark = loads_a;
    go();
    send_msb(8'hC3, 8);
    chk("h_load1", ld[0], 1);
    chk("h_data1", dat[0], 8'hC3);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("h_load_once", ld[0], 0);
    chk("h_busy", bsy[0], 1);
    send_msb(8'h01, 8);
    chk("h_load2", ld[0], 1);
    chk("h_data2", dat[0], 8'h01);
    tick();
    chk("h_idle", ld[0], 0);
    chk("h_load_count", loads_a - mark, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/deser_load_ctrl.md
Name: deser_load_ctrl

Overview:
- Serial-to-parallel front end for a bank of load-enabled D flip-flop register cells.
- Accepts a framed serial bit stream over a valid/ready handshake and assembles a WIDTH-bit word.
- Optionally checks even parity on the word.
- Presents the word on a stable parallel bus and issues a single-cycle load strobe. That strobe drives the load inputs of the downstream register bank directly.

Parameters:
- WIDTH, 8: bits per word. Legal range 2..32.
- MSB_FIRST, 1: 1 = first accepted bit lands in data[WIDTH-1]; 0 = first accepted bit lands in data[0].
- PARITY_EN, 0: 1 = one extra even-parity bit follows the WIDTH data bits.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset. Asserting it clears all state immediately; release is synchronised externally.
- start  in  1  frame start. Sampled on clk.
- in_valid  in  1  in_bit is valid this cycle.
- in_bit  in  1  serial data bit.
- in_ready  out  1  block accepts a bit this cycle. A bit is transferred when in_valid & in_ready.
- load  out  1  one-cycle strobe to the downstream register bank.
- data  out  WIDTH  assembled word. Stable between load strobes.
- busy  out  1  frame in progress (states SHIFT or PARITY).
- error  out  1  parity failure of the last frame. Sticky until the next start or reset.

Behaviour:
- Reset (reset=0), asynchronous:
  - state=IDLE, bit counter=0, shift register=0.
  - data=0, load=0, in_ready=0, busy=0, error=0.
- States: IDLE, SHIFT, PARITY, LOAD. Outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 -> SHIFT. Counter and shift register clear, error clears.
- SHIFT:
  - in_ready=1, busy=1.
  - On each transfer, the bit shifts in (direction set by MSB_FIRST) and the counter increments.
  - A transfer with counter=WIDTH-1 -> PARITY if PARITY_EN=1, else LOAD.
  - in_valid=0 holds state; gaps of any length are allowed.
- PARITY (PARITY_EN=1 only):
  - in_ready=1, busy=1.
  - On transfer, if XOR of the shift register and in_bit is 0 -> LOAD.
  - Otherwise -> IDLE with error=1. No load is issued and data is unchanged.
- LOAD:
  - load=1 for exactly this one cycle. in_ready=0, busy=0.
  - data is updated from the shift register on the clock edge that enters LOAD, so data is already valid during the load cycle. It then holds until the next LOAD.
  - Next state: SHIFT if start=1 (new frame, counter cleared, error cleared), else IDLE.
- Latency: the last bit is transferred at edge N; load=1 and the new data are present in cycle N+1. Minimum frame length is WIDTH(+1) transfer cycles + 1 load cycle.
- start=1 in SHIFT or PARITY:
  - Aborts the current frame and restarts SHIFT with counter=0 and error=0.
  - A bit transferred in the same cycle is discarded.
  - No load is issued for the aborted frame.
- reset mid-frame: the frame is discarded and data returns to 0. The downstream bank sees no load.
- Counter width is clog2(WIDTH+1). Counter never exceeds WIDTH-1 in SHIFT.
- in_bit is ignored whenever in_ready=0.

Test Plan:
- WIDTH=8, MSB_FIRST=1, PARITY_EN=0: start, then bits 1,0,1,0,0,1,0,1 back-to-back -> load=1 exactly one cycle after the 8th transfer, data=0xA5. data holds 0xA5 afterwards and load=0.
- Same stream with MSB_FIRST=0 and in_valid low for 3 cycles between bits 4 and 5 -> data=0xA5 (bit-reversed order in), load one cycle after the last transfer, busy=1 throughout the gap.
- PARITY_EN=1: 0xA5 with parity bit 0 -> load, data=0xA5, error=0. 0x3C with parity bit 1 -> no load, data stays 0xA5, error=1 until the next start.
- Restart: start, 5 bits, start again, then full 0xFF -> single load, data=0xFF. No load after the first 5 bits.
- reset pulled low after 4 bits of a frame -> in_ready, busy, load, data, error all 0 immediately. A subsequent full frame of 0x5A loads correctly.
- start held high during the LOAD cycle -> load pulses once and the block enters SHIFT. A following 0x01 frame produces a second load with data=0x01.
